enc_8b10b_lanes: RTL and testbench

- Parametrised, registered 8b/10b encoder for multi-byte words; next generation of the 5b/6b lookup stage.
- Encodes LANES bytes per beat using full 5b/6b + 3b/4b coding.
- Chains running disparity (RD) lane-to-lane within a beat and beat-to-beat.
- Sits between the framing logic and the serialiser; valid/ready on both sides.

---
 rtl/enc_8b10b_lanes.sv | 157 +++++++++++++++
 tb/tb_enc_8b10b_lanes.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/enc_8b10b_lanes.sv
// Registered multi-lane 8b/10b encoder; running disparity chains lane 0 -> LANES-1 and beat to beat.
// Optional macro RD_FORCE_EN adds in_rd_force/in_rd_val to override the lane-0 starting disparity.
module enc_8b10b_lanes #(
  parameter int   LANES   = 2,
  parameter logic RD_INIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*LANES-1:0]  in_data,
  input  logic [LANES-1:0]    in_k,
`ifdef RD_FORCE_EN
  input  logic                in_rd_force,
  input  logic                in_rd_val,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [10*LANES-1:0] out_code,
  output logic [LANES-1:0]    out_k_err,
  output logic                rd_out
);

  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // 5b/6b codes (abcdei) as used when the running disparity is negative.
  function automatic logic [5:0] d6_rdm(input logic [4:0] x);
    case (x)
      5'd0:  d6_rdm = 6'b100111;  5'd1:  d6_rdm = 6'b011101;
      5'd2:  d6_rdm = 6'b101101;  5'd3:  d6_rdm = 6'b110001;
      5'd4:  d6_rdm = 6'b110101;  5'd5:  d6_rdm = 6'b101001;
      5'd6:  d6_rdm = 6'b011001;  5'd7:  d6_rdm = 6'b111000;
      5'd8:  d6_rdm = 6'b111001;  5'd9:  d6_rdm = 6'b100101;
      5'd10: d6_rdm = 6'b010101;  5'd11: d6_rdm = 6'b110100;
      5'd12: d6_rdm = 6'b001101;  5'd13: d6_rdm = 6'b101100;
      5'd14: d6_rdm = 6'b011100;  5'd15: d6_rdm = 6'b010111;
      5'd16: d6_rdm = 6'b011011;  5'd17: d6_rdm = 6'b100011;
      5'd18: d6_rdm = 6'b010011;  5'd19: d6_rdm = 6'b110010;
      5'd20: d6_rdm = 6'b001011;  5'd21: d6_rdm = 6'b101010;
      5'd22: d6_rdm = 6'b011010;  5'd23: d6_rdm = 6'b111010;
      5'd24: d6_rdm = 6'b110011;  5'd25: d6_rdm = 6'b100110;
      5'd26: d6_rdm = 6'b010110;  5'd27: d6_rdm = 6'b110110;
      5'd28: d6_rdm = 6'b001110;  5'd29: d6_rdm = 6'b101110;
      5'd30: d6_rdm = 6'b011110;  5'd31: d6_rdm = 6'b101011;
      default: d6_rdm = 6'b000000;
    endcase
  endfunction

  function automatic logic [3:0] d4_rdm(input logic [2:0] y);
    case (y)
      3'd0: d4_rdm = 4'b1011;  3'd1: d4_rdm = 4'b1001;
      3'd2: d4_rdm = 4'b0101;  3'd3: d4_rdm = 4'b1100;
      3'd4: d4_rdm = 4'b1101;  3'd5: d4_rdm = 4'b1010;
      3'd6: d4_rdm = 4'b0110;  3'd7: d4_rdm = 4'b1110;
      default: d4_rdm = 4'b0000;
    endcase
  endfunction

  // K.28 3b/4b column: balanced entries are the complements of the D column.
  function automatic logic [3:0] k4_rdm(input logic [2:0] y);
    case (y)
      3'd0: k4_rdm = 4'b1011;  3'd1: k4_rdm = 4'b0110;
      3'd2: k4_rdm = 4'b1010;  3'd3: k4_rdm = 4'b1100;
      3'd4: k4_rdm = 4'b1101;  3'd5: k4_rdm = 4'b0101;
      3'd6: k4_rdm = 4'b1001;  3'd7: k4_rdm = 4'b0111;
      default: k4_rdm = 4'b0000;
    endcase
  endfunction

  function automatic logic k_legal(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                 (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction

  // Returns {rd_after, abcdeifghj}; k must already be masked to legal codes.
  function automatic logic [10:0] enc_lane(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       k28, unbal6, rd6, alt, unbal4;
    logic [5:0] six_n, six;
    logic [3:0] four_n, four;
    x      = b[4:0];
    y      = b[7:5];
    k28    = k && (x == 5'd28);
    six_n  = k28 ? 6'b001111 : d6_rdm(x);
    unbal6 = (ones6(six_n) != 3'd3);
    six    = (rd && (unbal6 || (x == 5'd7))) ? ~six_n : six_n;
    rd6    = rd ^ unbal6;
    alt    = (y == 3'd7) &&
             (k || (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                   ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
    four_n = alt ? 4'b0111 : (k28 ? k4_rdm(y) : d4_rdm(y));
    unbal4 = (ones6({2'b00, four_n}) != 3'd2);
    four   = (rd6 && (k28 || unbal4 || (y == 3'd3))) ? ~four_n : four_n;
    return {rd6 ^ unbal4, six, four};
  endfunction

  logic                out_valid_r;
  logic [10*LANES-1:0] code_r;
  logic [LANES-1:0]    kerr_r;
  logic                rd_r;
  logic [10*LANES-1:0] code_s;
  logic [LANES-1:0]    kerr_s;
  logic [10:0]         lane_s;
  logic                rd_start_s, rd_lane_s, accept_s;

`ifdef RD_FORCE_EN
  assign rd_start_s = in_rd_force ? in_rd_val : rd_r;
`else
  assign rd_start_s = rd_r;
`endif

  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_code  = code_r;
  assign out_k_err = kerr_r;
  assign rd_out    = rd_r;

  // Combinational lane chain: each lane starts from the disparity left by the previous one.
  always_comb begin
    code_s    = {(10*LANES){1'b0}};
    kerr_s    = {LANES{1'b0}};
    lane_s    = 11'd0;
    rd_lane_s = rd_start_s;
    for (int i = 0; i < LANES; i++) begin
      kerr_s[i]          = in_k[i] && !k_legal(in_data[8*i +: 8]);
      lane_s             = enc_lane(in_data[8*i +: 8], in_k[i] && !kerr_s[i], rd_lane_s);
      code_s[10*i +: 10] = lane_s[9:0];
      rd_lane_s          = lane_s[10];
    end
  end

  // Output register and running disparity; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      code_r      <= {(10*LANES){1'b0}};
      kerr_r      <= {LANES{1'b0}};
      rd_r        <= RD_INIT;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      code_r      <= code_s;
      kerr_r      <= kerr_s;
      rd_r        <= rd_lane_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enc_8b10b_lanes.sv
// Self-checking bench for enc_8b10b_lanes: table-driven reference model plus directed literal checks.
module tb_enc_8b10b_lanes;
  localparam int LANES = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [8*LANES-1:0]  in_data = '0;
  logic [LANES-1:0]    in_k = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [10*LANES-1:0] out_code;
  logic [LANES-1:0]    out_k_err;
  logic                rd_out;

  int errors = 0;
  int checks = 0;

  enc_8b10b_lanes #(.LANES(LANES), .RD_INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_k(in_k),
`ifdef RD_FORCE_EN
    .in_rd_force(1'b0), .in_rd_val(1'b0),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_k_err(out_k_err), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // Standard tables, both disparity columns written out.
  logic [5:0] d6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
    6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
    6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
    6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
    6'b011110, 6'b101011};
  logic [5:0] d6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
    6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
    6'b011100, 6'b101000, 6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
    6'b011010, 6'b000101, 6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
    6'b100001, 6'b010100};
  logic [3:0] d4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] d4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

  function automatic logic k_ok(input logic [7:0] b);
    int x, y;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    return (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
  endfunction

  // Disparity after a block is judged from its ones count, independent of which code was chosen.
  function automatic logic [10:0] model_sym(input logic [7:0] b, input logic k, input logic rd);
    int x, y, o;
    logic [5:0] s;
    logic [3:0] f;
    logic r6, rf;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    if (k && x == 28) s = rd ? 6'b110000 : 6'b001111;
    else              s = rd ? d6p[x] : d6n[x];
    o  = $countones(s);
    r6 = (o > 3) ? 1'b1 : ((o < 3) ? 1'b0 : rd);
    if (k && x == 28) f = r6 ? k4p[y] : k4n[y];
    else if (y == 7 && (k || (!r6 && (x == 17 || x == 18 || x == 20)) ||
                             (r6 && (x == 11 || x == 13 || x == 14))))
      f = r6 ? 4'b1000 : 4'b0111;
    else f = r6 ? d4p[y] : d4n[y];
    o  = $countones({s, f});
    rf = (o > 5) ? 1'b1 : ((o < 5) ? 1'b0 : rd);
    return {rf, s, f};
  endfunction

  task automatic model_beat(input logic [8*LANES-1:0] d, input logic [LANES-1:0] k, input logic rd_i,
                            output logic [10*LANES-1:0] code, output logic [LANES-1:0] kerr,
                            output logic rd_o);
    logic [10:0] s;
    logic r;
    r = rd_i;
    for (int i = 0; i < LANES; i++) begin
      kerr[i] = k[i] && !k_ok(d[8*i +: 8]);
      s = model_sym(d[8*i +: 8], k[i] && !kerr[i], r);
      code[10*i +: 10] = s[9:0];
      r = s[10];
    end
    rd_o = r;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic                m_valid = 1'b0;
  logic [10*LANES-1:0] m_code = '0;
  logic [LANES-1:0]    m_kerr = '0;
  logic                m_rd = 1'b0;
  logic [10*LANES-1:0] n_code;
  logic [LANES-1:0]    n_kerr;
  logic                n_rd;

  // Reference: one output slot with valid/ready semantics.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_code  <= '0;
      m_kerr  <= '0;
      m_rd    <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      model_beat(in_data, in_k, m_rd, n_code, n_kerr, n_rd);
      m_valid <= 1'b1;
      m_code  <= n_code;
      m_kerr  <= n_kerr;
      m_rd    <= n_rd;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    chk("rd_out", {31'd0, rd_out}, {31'd0, m_rd});
    if (m_valid) begin
      chk("out_code", {12'd0, out_code}, {12'd0, m_code});
      chk("out_k_err", {30'd0, out_k_err}, {30'd0, m_kerr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [19:0] code, input logic [1:0] kerr, input logic rd);
    chk({name, "_code"}, {12'd0, out_code}, {12'd0, code});
    chk({name, "_kerr"}, {30'd0, out_k_err}, {30'd0, kerr});
    chk({name, "_rd"}, {31'd0, rd_out}, {31'd0, rd});
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  logic [7:0] b;

  initial begin
    chk("model_d0_rdm", {21'd0, model_sym(8'h00, 1'b0, 1'b0)}, {21'd0, 1'b0, 10'b1001110100});
    chk("model_k285_rdp", {21'd0, model_sym(8'hBC, 1'b1, 1'b1)}, {21'd0, 1'b0, 10'b1100000101});
    chk("model_k285_rdm", {21'd0, model_sym(8'hBC, 1'b1, 1'b0)}, {21'd0, 1'b1, 10'b0011111010});
    chk("model_d177_rdm", {21'd0, model_sym(8'hF1, 1'b0, 1'b0)}, {21'd0, 1'b1, 10'b1000110111});
    chk("model_d215_rdp", {21'd0, model_sym(8'hB5, 1'b0, 1'b1)}, {21'd0, 1'b1, 10'b1010101010});

    repeat (2) step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_code", {12'd0, out_code}, 32'd0);
    chk("rst_kerr", {30'd0, out_k_err}, 32'd0);
    chk("rst_rd", {31'd0, rd_out}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    in_valid = 1'b1; in_data = 16'h0000; in_k = 2'b00;
    step(); pin("d00", 20'b1001110100_1001110100, 2'b00, 1'b0);
    in_data = 16'h0000; in_k = 2'b01;
    step(); pin("kbad", 20'b1001110100_1001110100, 2'b01, 1'b0);
    in_data = 16'hB5F1; in_k = 2'b00;
    step(); pin("d177", 20'b1010101010_1000110111, 2'b00, 1'b1);
    in_data = 16'hBCBC; in_k = 2'b11;
    step(); pin("k285", 20'b0011111010_1100000101, 2'b00, 1'b1);

    in_data = 16'h0000; in_k = 2'b00; out_ready = 1'b0;
    #1 chk("stall_ready0", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      pin("stall", 20'b0011111010_1100000101, 2'b00, 1'b1);
    end
    out_ready = 1'b1;
    step(); pin("nobubble", 20'b0110001011_0110001011, 2'b00, 1'b1);

    out_ready = 1'b0; in_data = 16'hB5F1;
    step();
    #2 rst = 1'b1;
    #1 chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_rd", {31'd0, rd_out}, 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b1; in_data = 16'h0000;
    step(); pin("after_rst", 20'b1001110100_1001110100, 2'b00, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++) begin
        b = 8'($urandom);
        in_k[i] = ($urandom_range(0, 3) == 0);
        if (in_k[i] && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 4))
            0: b = 8'hF7;
            1: b = 8'hFB;
            2: b = 8'hFD;
            3: b = 8'hFE;
            default: b = {b[7:5], 5'd28};
          endcase
        end
        in_data[8*i +: 8] = b;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
